mac_acc_36: RTL and testbench
=============================

# mac_acc_36

Accumulating reduction stage that consumes the two packed product buses of the 36-lane parallel multiplier array and turns them into two dot-product results. Per accepted beat it sums all N signed 16-bit lanes of each bus through a pipelined adder tree and accumulates over a programmed number of beats. It then presents both sums on a valid/ready output port. It sits between the multiplier array and the result writeback/requantisation logic in the MAC core.

## Interface
- N, 36, lanes per product bus (1..64)
- PW, 16, signed product width per lane
- ACC_W, 32, signed accumulator/result width (≥ PW+6)
- LEN_W, 16, beat-count width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- prod1  in  PW*N  lane products, channel 1, lane i at bits [PW*(i+1)-1 -: PW]
- prod2  in  PW*N  lane products, channel 2, same packing
- prod_vld  in  1  both product buses valid this cycle
- start  in  1  begin job (sampled in IDLE only)
- len  in  LEN_W  beats per job, latched on start
- out_data1  out  ACC_W  channel-1 result
- out_data2  out  ACC_W  channel-2 result
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts result
- busy  out  1  state ≠ IDLE
- ovf  out  1  sticky per-job overflow flag

## Operation
- States: IDLE, RUN, DRAIN, HOLD.
- IDLE: start=1 and len≠0 → latch len, clear both accumulators, beat counter and ovf → RUN. start with len=0 is ignored.
- RUN: each cycle with prod_vld=1 is one accepted beat and increments the counter. Accepting beat number len → DRAIN. prod_vld gaps are allowed.
- DRAIN: lasts until the final beat has left the tree and reached the accumulator (fixed 4-cycle window) → HOLD.
- HOLD: out_vld=1, data stable. out_vld&out_rdy → IDLE.
- prod_vld outside RUN is ignored; start outside IDLE is ignored. This includes a start in the same cycle as the HOLD handshake.
- Tree: every lane is sign-extended. The tree is padded with zero lanes to 64. It has 6 adder levels, with pipeline registers after levels 2, 4 and 6. A valid bit travels alongside the data.
- Accumulator: adds the tree output, sign-extended to ACC_W, when the valid bit reaches the end of the tree.

## Timing
- Reset values: out_data1=0, out_data2=0, out_vld=0, busy=0, ovf=0, state IDLE, all pipeline valids 0.
- Final beat accepted at edge t → out_vld=1 after edge t+4.
- Throughput: one beat per clock in RUN.
- busy rises the cycle after the start edge and falls after the handshake edge.
- Reset mid-job aborts immediately. In-flight beats are discarded and no result is emitted.
- Minimum job (len=1): start edge s, beat at s+1, out_vld after s+5.

## Configuration
- MAC_ACC_SAT_EN defined:
  - The accumulator saturates to the signed ACC_W max/min on overflow.
  - ovf sets and stays set until the next start.
  - Once saturated, a channel holds its clamp value only while further beats push in the same direction.
- MAC_ACC_SAT_EN undefined:
  - Two's-complement wrap-around.
  - ovf is tied to 0.

## Structure
- Package mac_pkg holds:
  - PW and TREE_LAT=3 constants.
  - State enum typedef (IDLE/RUN/DRAIN/HOLD).
  - The saturating-add function, guarded by MAC_ACC_SAT_EN.
- Sub-module add_tree_36: parameterised N/PW signed pipelined reduction with in/out valid. It is instantiated twice, once per channel.
- Top module holds the FSM, beat counter, drain counter, accumulators and output register.

## Test plan
- All prod1 lanes=1, all prod2 lanes=−2, len=4, prod_vld continuous → out_data1=144, out_data2=−288, out_vld 4 cycles after the 4th beat, ovf=0.
- Same job with prod_vld toggling 1,0,0,1,… → identical results; beats counted only on prod_vld=1.
- ACC_W=24, all lanes=32767, len=8 → with MAC_ACC_SAT_EN: 8388607, ovf=1; without: −7340320, ovf=0.
- Hold out_rdy=0 for 5 cycles in HOLD, pulse start and prod_vld meanwhile → out_vld and data stable, start and prod_vld ignored; out_rdy=1 → IDLE next cycle.
- Assert rst_n=0 at beat 2 of a len=6 job → all outputs 0 and no out_vld. A following len=1 job with lanes=3 gives out_data1=108.
- start with len=0, and prod_vld in IDLE → busy stays 0, no out_vld.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, FSM state type and the saturating-add helper
// for the mac_acc_36 reduction stage.
// Optional feature macro: MAC_ACC_SAT_EN (saturating accumulation).
package mac_pkg;

    // Signed product width per lane.
    localparam int PW       = 16;
    // Pipeline depth of the adder tree (registers after levels 2, 4 and 6).
    localparam int TREE_LAT = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_e;

`ifdef MAC_ACC_SAT_EN
    typedef struct packed {
        logic signed [63:0] sum;
        logic               ovf;
    } sat_res_t;

    // Adds two values that each fit in w signed bits and clamps the result
    // to the signed w-bit range; ovf reports that clamping took place.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        sat_res_t           r;
        logic signed [63:0] s;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        s     = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        r.ovf = 1'b0;
        r.sum = s;
        if (s > max_v) begin
            r.sum = max_v;
            r.ovf = 1'b1;
        end else if (s < min_v) begin
            r.sum = min_v;
            r.ovf = 1'b1;
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/add_tree_36.sv
// add_tree_36: signed pipelined reduction of N lanes (zero-padded to 64)
// through six adder levels, registered after levels 2, 4 and 6. A valid bit
// travels alongside the data.
module add_tree_36 #(
    parameter int N  = 36,
    parameter int PW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PW*N-1:0]      lanes_i,
    input  logic                 vld_i,
    output logic signed [PW+5:0] sum_o,
    output logic                 vld_o
);

    // Sum width: 64 lanes of PW bits need 6 extra bits.
    localparam int SW = PW + 6;

    logic signed [SW-1:0] l0   [64];
    logic signed [SW-1:0] l1   [32];
    logic signed [SW-1:0] l2_d [16];
    logic signed [SW-1:0] l2_q [16];
    logic signed [SW-1:0] l3   [8];
    logic signed [SW-1:0] l4_d [4];
    logic signed [SW-1:0] l4_q [4];
    logic signed [SW-1:0] l5   [2];
    logic signed [SW-1:0] l6_d;
    logic signed [SW-1:0] l6_q;
    logic [2:0]           vld_q;

    // Sign-extend real lanes, pad the rest of the 64-wide tree with zeros.
    for (genvar g = 0; g < 64; g++) begin : g_lane
        if (g < N) begin : g_real
            assign l0[g] = SW'(signed'(lanes_i[PW*(g+1)-1 -: PW]));
        end else begin : g_pad
            assign l0[g] = '0;
        end
    end

    // Adder level 1.
    always_comb begin
        for (int i = 0; i < 32; i++) l1[i] = l0[2*i] + l0[2*i+1];
    end

    // Adder level 2.
    always_comb begin
        for (int i = 0; i < 16; i++) l2_d[i] = l1[2*i] + l1[2*i+1];
    end

    // Adder level 3.
    always_comb begin
        for (int i = 0; i < 8; i++) l3[i] = l2_q[2*i] + l2_q[2*i+1];
    end

    // Adder level 4.
    always_comb begin
        for (int i = 0; i < 4; i++) l4_d[i] = l3[2*i] + l3[2*i+1];
    end

    // Adder levels 5 and 6.
    always_comb begin
        for (int i = 0; i < 2; i++) l5[i] = l4_q[2*i] + l4_q[2*i+1];
        l6_d = l5[0] + l5[1];
    end

    // Pipeline data registers.
    // NOTE: the wide data registers carry no reset; only the valid bits decide
    // whether their contents are ever consumed.
    always_ff @(posedge clk) begin
        l2_q <= l2_d;
        l4_q <= l4_d;
        l6_q <= l6_d;
    end

    // Valid bit shifts alongside the data.
    // NOTE: non-blocking assignment lets every stage see the previous value,
    // which is what makes this a shift register rather than a wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= {vld_q[1:0], vld_i};
    end

    assign sum_o = l6_q;
    assign vld_o = vld_q[2];

endmodule

// File: rtl/mac_acc_36.sv
// mac_acc_36: accumulating dot-product stage for two packed product buses.
// Each accepted beat is reduced by an adder tree per channel and summed into
// an accumulator over a programmed number of beats; both results are then
// held on a valid/ready port.
// Optional feature macro: MAC_ACC_SAT_EN (saturate instead of wrap, sticky ovf).
module mac_acc_36
    import mac_pkg::*;
#(
    parameter int N     = 36,
    parameter int PW    = mac_pkg::PW,
    parameter int ACC_W = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PW*N-1:0]  prod1,
    input  logic [PW*N-1:0]  prod2,
    input  logic             prod_vld,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic [ACC_W-1:0] out_data1,
    output logic [ACC_W-1:0] out_data2,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             busy,
    output logic             ovf
);

    localparam int SW = PW + 6;

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               drn_q, drn_d;
    logic signed [ACC_W-1:0]  acc1_q, acc1_d, acc2_q, acc2_d;
    logic [ACC_W-1:0]         out1_q, out1_d, out2_q, out2_d;
    logic                     beat;
    logic signed [SW-1:0]     t1_sum, t2_sum;
    logic                     t1_vld, t2_vld, t_vld;

    // Products count only while a job is running.
    assign beat  = (state_q == RUN) && prod_vld;
    assign t_vld = t1_vld & t2_vld;

    add_tree_36 #(.N(N), .PW(PW)) u_tree1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .lanes_i (prod1),
        .vld_i   (beat),
        .sum_o   (t1_sum),
        .vld_o   (t1_vld)
    );

    add_tree_36 #(.N(N), .PW(PW)) u_tree2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .lanes_i (prod2),
        .vld_i   (beat),
        .sum_o   (t2_sum),
        .vld_o   (t2_vld)
    );

`ifdef MAC_ACC_SAT_EN
    logic     ovf_q, ovf_d;
    sat_res_t r1, r2;

    assign r1  = sat_add(64'(acc1_q), 64'(t1_sum), ACC_W);
    assign r2  = sat_add(64'(acc2_q), 64'(t2_sum), ACC_W);
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Next-state logic: FSM, beat/drain counters, accumulators, output capture.
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
`ifdef MAC_ACC_SAT_EN
        ovf_d   = ovf_q;
`endif

        if (t_vld) begin
`ifdef MAC_ACC_SAT_EN
            acc1_d = r1.sum[ACC_W-1:0];
            acc2_d = r2.sum[ACC_W-1:0];
            ovf_d  = ovf_q | r1.ovf | r2.ovf;
`else
            acc1_d = acc1_q + ACC_W'(t1_sum);
            acc2_d = acc2_q + ACC_W'(t2_sum);
`endif
        end

        unique case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = RUN;
                    len_d   = len;
                    cnt_d   = '0;
                    acc1_d  = '0;
                    acc2_d  = '0;
`ifdef MAC_ACC_SAT_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (prod_vld) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if ((cnt_q + LEN_W'(1)) == len_q) begin
                        state_d = DRAIN;
                        drn_d   = '0;
                    end
                end
            end
            DRAIN: begin
                // The last beat reaches the accumulator TREE_LAT edges after
                // acceptance; capture one edge later.
                if (drn_q == 2'(TREE_LAT)) begin
                    state_d = HOLD;
                    out1_d  = acc1_q;
                    out2_d  = acc2_q;
                end else begin
                    drn_d = drn_q + 2'd1;
                end
            end
            HOLD: begin
                if (out_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
        end
    end

`ifdef MAC_ACC_SAT_EN
    // Sticky overflow flag, cleared by the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
`endif

    assign out_data1 = out1_q;
    assign out_data2 = out2_q;
    assign out_vld   = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_acc_36.sv
// tb_mac_acc_36: randomized and directed jobs against a dot-product model;
// expected results are queued by the driver and checked by a monitor when
// out_vld appears. Honours MAC_ACC_SAT_EN the same way as the design.
module tb_mac_acc_36;

    localparam int N     = 36;
    localparam int PW    = 16;
    localparam int ACC_W = 24;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PW*N-1:0]  prod1 = '0;
    logic [PW*N-1:0]  prod2 = '0;
    logic             prod_vld = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [ACC_W-1:0] out_data1;
    logic [ACC_W-1:0] out_data2;
    logic             out_vld;
    logic             out_rdy = 1'b0;
    logic             busy;
    logic             ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        longint d1;
        longint d2;
        bit     ov;
        int     rise;
    } exp_t;

    exp_t q[$];

    mac_acc_36 #(.N(N), .PW(PW), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod1     (prod1),
        .prod2     (prod2),
        .prod_vld  (prod_vld),
        .start     (start),
        .len       (len),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: two's-complement wrap of a plain integer into ACC_W bits.
    function automatic longint wrap_acc(input longint v);
        longint m;
        longint r;
        m = longint'(1) << ACC_W;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Reference: one beat added into an accumulator value.
    function automatic void acc_step(inout longint a, inout bit ov, input longint s);
        longint max_v;
        longint min_v;
        max_v = (longint'(1) << (ACC_W - 1)) - 1;
        min_v = -(longint'(1) << (ACC_W - 1));
        a = a + s;
`ifdef MAC_ACC_SAT_EN
        if (a > max_v) begin a = max_v; ov = 1'b1; end
        if (a < min_v) begin a = min_v; ov = 1'b1; end
`else
        if (max_v < min_v) ov = 1'b1;
`endif
    endfunction

    // Drive both buses: mode 0 random lanes, otherwise every lane v1 / v2.
    task automatic drive_lanes(input int mode, input int v1, input int v2,
                               output longint s1, output longint s2);
        s1 = 0;
        s2 = 0;
        for (int i = 0; i < N; i++) begin
            int a;
            int b;
            if (mode == 0) begin
                a = int'($urandom_range(65535, 0)) - 32768;
                b = int'($urandom_range(65535, 0)) - 32768;
            end else begin
                a = v1;
                b = v2;
            end
            prod1[PW*i +: PW] = 16'(a);
            prod2[PW*i +: PW] = 16'(b);
            s1 += a;
            s2 += b;
        end
    endtask

    // One complete job. gap<0 gives random gaps; hold is the number of HOLD
    // cycles with out_rdy low; poke drives start/prod_vld while they must be ignored.
    task automatic run_job(input int jlen, input int mode, input int v1, input int v2,
                           input int gap, input int hold, input bit poke);
        exp_t   e;
        longint a1 = 0;
        longint a2 = 0;
        longint s1;
        longint s2;
        longint junk1;
        longint junk2;
        bit     ov = 1'b0;
        int     t_last = 0;
        int     n;

        start = 1'b1;
        len   = LEN_W'(jlen);
        tick();
        start = 1'b0;
        check("busy_rise", busy, 1);

        for (int b = 0; b < jlen; b++) begin
            int ng;
            ng = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
            if (b > 0) begin
                for (int g = 0; g < ng; g++) begin
                    prod_vld = 1'b0;
                    drive_lanes(0, 0, 0, junk1, junk2);
                    tick();
                end
            end
            drive_lanes(mode, v1, v2, s1, s2);
            prod_vld = 1'b1;
            tick();
            t_last = cyc;
            prod_vld = 1'b0;
            acc_step(a1, ov, s1);
            acc_step(a2, ov, s2);
        end

        e.d1   = wrap_acc(a1);
        e.d2   = wrap_acc(a2);
`ifdef MAC_ACC_SAT_EN
        e.ov   = ov;
`else
        e.ov   = 1'b0;
`endif
        e.rise = t_last + 4;
        q.push_back(e);

        n = 0;
        while (out_vld !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("out_vld_seen", out_vld, 1);

        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                start    = 1'b1;
                len      = 16'd3;
                prod_vld = 1'b1;
            end
            tick();
        end
        start    = 1'b0;
        prod_vld = 1'b0;

        out_rdy = 1'b1;
        if (poke) begin
            start = 1'b1;
            len   = 16'd2;
        end
        tick();
        out_rdy = 1'b0;
        start   = 1'b0;
        check("busy_after_handshake", busy, 0);
        check("out_vld_after_handshake", out_vld, 0);
    endtask

    // Monitor: compares each presented result against the queue head.
    initial begin : monitor
        bit               prev_vld = 1'b0;
        bit               have = 1'b0;
        logic [ACC_W-1:0] cap1;
        logic [ACC_W-1:0] cap2;
        exp_t             cur;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 1'b0;
                have     = 1'b0;
            end else begin
                if (out_vld && !prev_vld) begin
                    if (q.size() == 0) begin
                        check("spurious_out_vld", out_vld, 0);
                    end else begin
                        cur = q[0];
                        check("out_data1", $signed(out_data1), cur.d1);
                        check("out_data2", $signed(out_data2), cur.d2);
                        check("ovf", ovf, cur.ov);
                        check("latency", cyc, cur.rise);
                        cap1 = out_data1;
                        cap2 = out_data2;
                        have = 1'b1;
                    end
                end else if (out_vld && have) begin
                    check("hold_data1_stable", out_data1, cap1);
                    check("hold_data2_stable", out_data2, cap2);
                end
                if (out_vld && out_rdy && have) begin
                    void'(q.pop_front());
                    have = 1'b0;
                end
                prev_vld = out_vld;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : driver
        longint s1;
        longint s2;

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_out_data1", out_data1, 0);
        check("reset_out_data2", out_data2, 0);
        check("reset_out_vld", out_vld, 0);
        check("reset_busy", busy, 0);
        check("reset_ovf", ovf, 0);

        // start with len=0 and prod_vld in IDLE are ignored.
        start = 1'b1;
        len   = '0;
        tick();
        start = 1'b0;
        check("len0_busy", busy, 0);
        prod_vld = 1'b1;
        repeat (3) tick();
        prod_vld = 1'b0;
        repeat (6) tick();
        check("idle_prod_vld_busy", busy, 0);
        check("idle_prod_vld_out_vld", out_vld, 0);

        // All ones / minus twos, continuous then with gaps.
        run_job(4, 1, 1, -2, 0, 0, 1'b0);
        run_job(4, 1, 1, -2, 2, 0, 1'b0);

        // Overflow in both directions.
        run_job(8, 1, 32767, -32768, 0, 1, 1'b0);

        // Long HOLD with ignored start/prod_vld, also start on the handshake.
        run_job(3, 0, 0, 0, 0, 5, 1'b1);

        // Reset in the middle of a len=6 job.
        start = 1'b1;
        len   = 16'd6;
        tick();
        start = 1'b0;
        drive_lanes(1, 1000, -1000, s1, s2);
        prod_vld = 1'b1;
        tick();
        drive_lanes(1, 2000, -2000, s1, s2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_data1", out_data1, 0);
        check("midreset_out_data2", out_data2, 0);
        check("midreset_out_vld", out_vld, 0);
        check("midreset_busy", busy, 0);
        check("midreset_ovf", ovf, 0);
        prod_vld = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("after_reset_out_vld", out_vld, 0);
        check("after_reset_busy", busy, 0);

        // Minimum job.
        run_job(1, 1, 3, -5, 0, 0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 20; j++) begin
            run_job(int'($urandom_range(6, 1)), 0, 0, 0, -1,
                    int'($urandom_range(3, 0)), bit'($urandom_range(1, 0)));
        end

        repeat (10) tick();
        check("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
